nios_hello_ram_tester: RTL and testbench

Avalon-MM master that fills a word region of the on-chip RAM with a deterministic pattern and optionally reads it back and checks every word. It sits in the Platform Designer system beside the Nios II data master and connects to the RAM's s2 slave port. It is used for power-on memory self-test and for bring-up debug. Software or a start strobe launches it, then polls busy/done and the error counters.

---
 rtl/nios_hello_ram_tester.sv | 146 ++++++++++++++
 tb/tb_nios_hello_ram_tester.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_hello_ram_tester.sv
// Avalon-MM RAM fill/verify engine: writes seed+i to word base_addr+i, optionally reads back and counts mismatches.
// Registered outputs, first write the cycle after start; holds requests under waitrequest, one read in flight.
module nios_hello_ram_tester #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic [31:0]       seed,
  input  logic              verify,
  output logic              busy,
  output logic              done,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [ADDR_W+1:0] avm_address,
  output logic [3:0]        avm_byteenable,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest,
  input  logic              avm_readdatavalid
);

  typedef enum logic [2:0] {IDLE, WRITE, READ_REQ, READ_WAIT, DONE} state_t;

  localparam logic [ADDR_W:0] ONE_L = 1;

  state_t            state, state_nxt;
  logic [ADDR_W:0]   idx, idx_nxt, len_q, len_nxt;
  logic [ADDR_W-1:0] base_q, base_nxt, fea_nxt, cur_word, word_nxt;
  logic [31:0]       seed_q, seed_nxt;
  logic              verify_q, verify_nxt, err_seen, err_seen_nxt;
  logic [15:0]       err_nxt;
  logic              last;

  assign avm_byteenable = 4'hF;
  assign last           = (idx == len_q - ONE_L);
  assign cur_word       = base_q + idx[ADDR_W-1:0];
  assign word_nxt       = base_nxt + idx_nxt[ADDR_W-1:0];

  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    len_nxt      = len_q;
    base_nxt     = base_q;
    seed_nxt     = seed_q;
    verify_nxt   = verify_q;
    err_nxt      = err_count;
    fea_nxt      = first_err_addr;
    err_seen_nxt = err_seen;
    case (state)
      IDLE: begin
        if (start) begin
          len_nxt      = length;
          base_nxt     = base_addr;
          seed_nxt     = seed;
          verify_nxt   = verify;
          idx_nxt      = '0;
          err_nxt      = '0;
          fea_nxt      = '0;
          err_seen_nxt = 1'b0;
          state_nxt    = (length == '0) ? DONE : WRITE;
        end
      end
      WRITE: begin
        if (avm_write && !avm_waitrequest) begin
          if (!last) begin
            idx_nxt = idx + ONE_L;
          end else if (verify_q) begin
            idx_nxt   = '0;
            state_nxt = READ_REQ;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      READ_REQ: begin
        if (avm_read && !avm_waitrequest) state_nxt = READ_WAIT;
      end
      READ_WAIT: begin
        if (avm_readdatavalid) begin
          if (avm_readdata != seed_q + 32'(idx)) begin
            if (err_count != 16'hFFFF) err_nxt = err_count + 16'd1;
            // A separate flag is needed because word 0 is a legal first-error address.
            if (!err_seen) begin
              fea_nxt      = cur_word;
              err_seen_nxt = 1'b1;
            end
          end
          if (last) begin
            state_nxt = DONE;
          end else begin
            idx_nxt   = idx + ONE_L;
            state_nxt = READ_REQ;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Bus outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx            <= '0;
      len_q          <= '0;
      base_q         <= '0;
      seed_q         <= '0;
      verify_q       <= 1'b0;
      err_seen       <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      avm_write      <= 1'b0;
      avm_read       <= 1'b0;
      avm_address    <= '0;
      avm_writedata  <= '0;
    end else begin
      idx            <= idx_nxt;
      len_q          <= len_nxt;
      base_q         <= base_nxt;
      seed_q         <= seed_nxt;
      verify_q       <= verify_nxt;
      err_seen       <= err_seen_nxt;
      err_count      <= err_nxt;
      first_err_addr <= fea_nxt;
      busy           <= (state_nxt != IDLE);
      done           <= (state_nxt == DONE);
      avm_write      <= (state_nxt == WRITE);
      avm_read       <= (state_nxt == READ_REQ);
      avm_address    <= {word_nxt, 2'b00};
      avm_writedata  <= seed_nxt + 32'(idx_nxt);
    end
  end

endmodule

// File: tb/tb_nios_hello_ram_tester.sv
// Bench for nios_hello_ram_tester: Avalon RAM slave model, transaction-queue reference model, directed runs.
module tb_nios_hello_ram_tester;
  localparam int AW = 16;

  logic          clk, reset, start, verify;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic [31:0]   seed;
  logic          busy, done;
  logic [15:0]   err_count;
  logic [AW-1:0] first_err_addr;
  logic [AW+1:0] avm_address;
  logic [3:0]    avm_byteenable;
  logic          avm_read, avm_write;
  logic [31:0]   avm_writedata, avm_readdata;
  logic          avm_waitrequest, avm_readdatavalid;

  int compared = 0;
  int mismatched = 0;
  int wr_acc = 0;
  int rd_acc = 0;
  int done_cnt = 0;

  logic [31:0]   mem [0:65535];
  bit            stall_en, fault_en, spurious_en;
  logic [AW-1:0] exp_wr_addr[$];
  logic [31:0]   exp_wr_data[$];
  logic [AW-1:0] exp_rd_addr[$];
  logic [15:0]   exp_err;
  logic [AW-1:0] exp_first;

  nios_hello_ram_tester #(.ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
    .seed(seed), .verify(verify), .busy(busy), .done(done), .err_count(err_count),
    .first_err_addr(first_err_addr), .avm_address(avm_address), .avm_byteenable(avm_byteenable),
    .avm_read(avm_read), .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
    .avm_readdatavalid(avm_readdatavalid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic bit is_bad(input logic [AW-1:0] w);
    return fault_en && (w == 16'h0005 || w == 16'h0007);
  endfunction

  // Slave: latency-1 RAM; reports acceptance of the previous cycle's request at each negedge.
  initial begin
    bit            pw, pr, pwait;
    logic [AW-1:0] paddr;
    logic [31:0]   pdata;
    pw = 1'b0; pr = 1'b0; pwait = 1'b0; paddr = '0; pdata = '0;
    avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0;
    forever begin
      @(negedge clk);
      avm_readdatavalid = 1'b0;
      if (reset) begin
        pw = 1'b0; pr = 1'b0; pwait = 1'b0;
        avm_waitrequest = 1'b0;
      end else begin
        if (pw && !pwait) mem[paddr] = pdata;
        if (pr && !pwait) begin
          avm_readdatavalid = 1'b1;
          avm_readdata      = mem[paddr] ^ {31'd0, is_bad(paddr)};
        end else if (spurious_en) begin
          avm_readdatavalid = 1'b1;
          avm_readdata      = 32'hBAD0_0000 ^ 32'($urandom);
        end
        pw = avm_write; pr = avm_read;
        paddr = avm_address[AW+1:2]; pdata = avm_writedata;
        avm_waitrequest = stall_en && ($urandom_range(0, 99) < 35);
        pwait = avm_waitrequest;
      end
    end
  end

  // Compare process: every bus request must match the head of the expected transaction queues.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!reset) begin
        chk("byteenable", 32'(avm_byteenable), 32'hF);
        chk("rd_wr_exclusive", 32'(avm_read && avm_write), 32'd0);
        if (avm_write) begin
          chk("wr_busy", 32'(busy), 32'd1);
          if (exp_wr_addr.size() == 0) begin
            compared++; mismatched++;
            $display("FAIL unexpected_write: addr 0x%05h data 0x%08h, no write expected", avm_address, avm_writedata);
          end else begin
            chk("wr_addr", 32'(avm_address), 32'({exp_wr_addr[0], 2'b00}));
            chk("wr_data", avm_writedata, exp_wr_data[0]);
            if (!avm_waitrequest) begin
              void'(exp_wr_addr.pop_front());
              void'(exp_wr_data.pop_front());
              wr_acc++;
            end
          end
        end
        if (avm_read) begin
          chk("rd_busy", 32'(busy), 32'd1);
          if (exp_rd_addr.size() == 0) begin
            compared++; mismatched++;
            $display("FAIL unexpected_read: addr 0x%05h, no read expected", avm_address);
          end else begin
            chk("rd_addr", 32'(avm_address), 32'({exp_rd_addr[0], 2'b00}));
            if (!avm_waitrequest) begin
              void'(exp_rd_addr.pop_front());
              rd_acc++;
            end
          end
        end
        if (done) begin
          done_cnt++;
          chk("done_busy", 32'(busy), 32'd1);
          chk("done_writes_left", 32'(exp_wr_addr.size()), 32'd0);
          chk("done_reads_left", 32'(exp_rd_addr.size()), 32'd0);
          chk("done_err_count", 32'(err_count), 32'(exp_err));
          chk("done_first_err", 32'(first_err_addr), 32'(exp_first));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load_model(input logic [AW-1:0] b, input logic [AW:0] n, input logic [31:0] s, input bit v);
    logic [AW-1:0] w;
    bit found;
    exp_wr_addr.delete(); exp_wr_data.delete(); exp_rd_addr.delete();
    exp_err = '0; exp_first = '0; found = 1'b0;
    for (int i = 0; i < int'(n); i++) begin
      w = b + 16'(i);
      exp_wr_addr.push_back(w);
      exp_wr_data.push_back(s + 32'(i));
      if (v) begin
        exp_rd_addr.push_back(w);
        if (is_bad(w)) begin
          if (exp_err != 16'hFFFF) exp_err = exp_err + 16'd1;
          if (!found) begin exp_first = w; found = 1'b1; end
        end
      end
    end
  endtask

  // lat = cycle (counted from the start cycle) in which done is seen.
  task automatic run(input logic [AW-1:0] b, input logic [AW:0] n, input logic [31:0] s,
                     input bit v, input bit hold, output int lat);
    load_model(b, n, s, v);
    base_addr = b; length = n; seed = s; verify = v; start = 1'b1;
    tick();
    lat = 1;
    chk("busy_after_start", 32'(busy), 32'd1);
    if (!hold) begin
      start = 1'b0;
    end else begin
      base_addr = ~b; length = n + 17'd3; seed = ~s; verify = ~v;
    end
    while (!done && lat < 4000) begin
      tick();
      lat++;
    end
    chk("done_seen", 32'(done), 32'd1);
    tick();
    start = 1'b0;
    chk("post_done_busy", 32'(busy), 32'd0);
    chk("post_done_pulse", 32'(done), 32'd0);
  endtask

  initial begin
    int lat, w0, r0, d0;
    reset = 1'b0; start = 1'b0; base_addr = '0; length = '0; seed = '0; verify = 1'b0;
    stall_en = 1'b0; fault_en = 1'b0; spurious_en = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_write", 32'(avm_write), 32'd0);
    chk("rst_read", 32'(avm_read), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_first_err", 32'(first_err_addr), 32'd0);
    chk("rst_address", 32'(avm_address), 32'd0);
    chk("rst_writedata", avm_writedata, 32'd0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    tick();

    // Fill-only, no stalls, stray readdatavalid pulses must be ignored.
    spurious_en = 1'b1; w0 = wr_acc;
    run(16'h0010, 17'd4, 32'hA000_0000, 1'b0, 1'b0, lat);
    spurious_en = 1'b0;
    chk("fill_latency", 32'(lat), 32'd5);
    chk("fill_writes", 32'(wr_acc - w0), 32'd4);
    chk("fill_mem0", mem[16'h0010], 32'hA000_0000);
    chk("fill_mem1", mem[16'h0011], 32'hA000_0001);
    chk("fill_mem2", mem[16'h0012], 32'hA000_0002);
    chk("fill_mem3", mem[16'h0013], 32'hA000_0003);
    chk("fill_err_count", 32'(err_count), 32'd0);

    // Fill + verify under random waitrequest.
    stall_en = 1'b1; w0 = wr_acc; r0 = rd_acc;
    run(16'h0100, 17'd256, 32'h1234_5678, 1'b1, 1'b0, lat);
    stall_en = 1'b0;
    chk("verify_writes", 32'(wr_acc - w0), 32'd256);
    chk("verify_reads", 32'(rd_acc - r0), 32'd256);
    chk("verify_err_count", 32'(err_count), 32'd0);
    chk("verify_min_latency", 32'(lat >= 769), 32'd1);

    // Fault injection on words 5 and 7; no stalls gives 1 + 8 + 2*8 cycles.
    fault_en = 1'b1;
    run(16'h0000, 17'd8, 32'h0000_1000, 1'b1, 1'b0, lat);
    fault_en = 1'b0;
    chk("fault_latency", 32'(lat), 32'd25);
    chk("fault_err_count", 32'(err_count), 32'd2);
    chk("fault_first_err", 32'(first_err_addr), 32'h0005);

    // Zero length: done straight away, counters cleared, no bus traffic.
    w0 = wr_acc; r0 = rd_acc;
    run(16'h1234, 17'd0, 32'h0000_0055, 1'b1, 1'b0, lat);
    chk("zero_latency", 32'(lat), 32'd1);
    chk("zero_writes", 32'(wr_acc - w0), 32'd0);
    chk("zero_reads", 32'(rd_acc - r0), 32'd0);
    chk("zero_err_cleared", 32'(err_count), 32'd0);
    chk("zero_first_cleared", 32'(first_err_addr), 32'd0);

    // Region wrapping past the top of RAM.
    run(16'hFFFE, 17'd4, 32'hC0DE_0000, 1'b0, 1'b0, lat);
    chk("wrap_latency", 32'(lat), 32'd5);
    chk("wrap_mem_fffe", mem[16'hFFFE], 32'hC0DE_0000);
    chk("wrap_mem_ffff", mem[16'hFFFF], 32'hC0DE_0001);
    chk("wrap_mem_0000", mem[16'h0000], 32'hC0DE_0002);
    chk("wrap_mem_0001", mem[16'h0001], 32'hC0DE_0003);

    // Reset in the middle of a fill after three accepted writes.
    w0 = wr_acc; d0 = done_cnt;
    load_model(16'h0200, 17'd8, 32'h7777_0000, 1'b0);
    base_addr = 16'h0200; length = 17'd8; seed = 32'h7777_0000; verify = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("midrst_writes", 32'(wr_acc - w0), 32'd3);
    reset = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_write", 32'(avm_write), 32'd0);
    chk("midrst_read", 32'(avm_read), 32'd0);
    chk("midrst_address", 32'(avm_address), 32'd0);
    chk("midrst_writedata", avm_writedata, 32'd0);
    chk("midrst_err_count", 32'(err_count), 32'd0);
    chk("midrst_first_err", 32'(first_err_addr), 32'd0);
    exp_wr_addr.delete(); exp_wr_data.delete(); exp_rd_addr.delete();
    repeat (3) tick();
    reset = 1'b0;
    repeat (10) tick();
    chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    chk("midrst_idle", 32'(busy), 32'd0);

    // start held high through busy and DONE with scrambled inputs: must neither relatch nor restart.
    w0 = wr_acc; r0 = rd_acc;
    run(16'h0300, 17'd4, 32'h0BAD_F00D, 1'b0, 1'b1, lat);
    chk("hold_latency", 32'(lat), 32'd5);
    repeat (4) tick();
    chk("hold_no_restart", 32'(busy), 32'd0);
    chk("hold_writes", 32'(wr_acc - w0), 32'd4);
    chk("hold_reads", 32'(rd_acc - r0), 32'd0);
    chk("hold_mem3", mem[16'h0303], 32'h0BAD_F010);

    run(16'h0400, 17'd3, 32'h0000_0001, 1'b0, 1'b0, lat);
    chk("after_hold_latency", 32'(lat), 32'd4);
    chk("after_hold_mem2", mem[16'h0402], 32'h0000_0003);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
